// File: rtl/rf_wb_queue.sv
// Writeback queue feeding the register file's single write port.
// Arbitrates slow/fast writeback sources into an in-order FIFO and serves decode bypass lookups.
module rf_wb_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          slow_valid,
    output logic                          slow_ready,
    input  logic [ADDR_WIDTH-1:0]         slow_addr,
    input  logic [DATA_WIDTH-1:0]         slow_data,
    input  logic                          fast_valid,
    output logic                          fast_ready,
    input  logic [ADDR_WIDTH-1:0]         fast_addr,
    input  logic [DATA_WIDTH-1:0]         fast_data,
    input  logic                          rf_ready,
    output logic [3:0]                    rf_wen,
    output logic [ADDR_WIDTH-1:0]         rf_waddr,
    output logic [DATA_WIDTH-1:0]         rf_wdata,
    input  logic [ADDR_WIDTH-1:0]         q_addr1,
    input  logic [ADDR_WIDTH-1:0]         q_addr2,
    output logic                          q_hit1,
    output logic                          q_hit2,
    output logic [DATA_WIDTH-1:0]         q_data1,
    output logic [DATA_WIDTH-1:0]         q_data2,
    output logic [$clog2(DEPTH):0]        q_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_slow_acc;
    logic                  w_fast_acc;
    logic                  w_push;
    logic                  w_pop;
    logic [ADDR_WIDTH-1:0] w_in_addr;
    logic [DATA_WIDTH-1:0] w_in_data;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends only on occupancy and slow_valid so the fast source never loops through us.
    assign slow_ready = !w_full;
    assign fast_ready = !w_full && !slow_valid;

    assign w_slow_acc = slow_valid && slow_ready;
    assign w_fast_acc = fast_valid && fast_ready;

    always_comb begin
        w_in_addr = fast_addr;
        w_in_data = fast_data;
        if (w_slow_acc) begin
            w_in_addr = slow_addr;
            w_in_data = slow_data;
        end
    end

    // Writes to r0 complete the handshake but are discarded.
    assign w_push = (w_slow_acc || w_fast_acc) && (w_in_addr != '0);
    assign w_pop  = !w_empty && rf_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            if (w_push) begin
                r_addr[r_tail] <= w_in_addr;
                r_data[r_tail] <= w_in_data;
                r_vld[r_tail]  <= 1'b1;
                r_tail         <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign rf_wen   = {4{!w_empty}};
    assign rf_waddr = w_empty ? '0 : r_addr[r_head];
    assign rf_wdata = w_empty ? '0 : r_data[r_head];
    assign q_count  = r_count;

    // Scan oldest to youngest so the last match found is the youngest.
    function automatic logic [DATA_WIDTH:0] lookup(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [PTR_W-1:0]      head,
        input logic [DEPTH-1:0]      vld
    );
        logic [PTR_W-1:0]      idx;
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
        hit  = 1'b0;
        data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if (vld[idx] && (r_addr[idx] == addr) && (addr != '0)) begin
                hit  = 1'b1;
                data = r_data[idx];
            end
        end
        return {hit, data};
    endfunction

    logic [DATA_WIDTH:0] w_q1;
    logic [DATA_WIDTH:0] w_q2;

    assign w_q1    = lookup(q_addr1, r_head, r_vld);
    assign w_q2    = lookup(q_addr2, r_head, r_vld);
    assign q_hit1  = w_q1[DATA_WIDTH];
    assign q_data1 = w_q1[DATA_WIDTH-1:0];
    assign q_hit2  = w_q2[DATA_WIDTH];
    assign q_data2 = w_q2[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: directed scenarios then random traffic against a queue-based reference model.
module tb_rf_wb_queue;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          slow_valid = 1'b0, fast_valid = 1'b0, rf_ready = 1'b0;
    logic          slow_ready, fast_ready;
    logic [AW-1:0] slow_addr = '0, fast_addr = '0, q_addr1 = '0, q_addr2 = '0;
    logic [DW-1:0] slow_data = '0, fast_data = '0;
    logic [3:0]    rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          q_hit1, q_hit2;
    logic [DW-1:0] q_data1, q_data2;
    logic [CW-1:0] q_count;

    rf_wb_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn),
        .slow_valid(slow_valid), .slow_ready(slow_ready), .slow_addr(slow_addr), .slow_data(slow_data),
        .fast_valid(fast_valid), .fast_ready(fast_ready), .fast_addr(fast_addr), .fast_data(fast_data),
        .rf_ready(rf_ready), .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_data1(q_data1), .q_data2(q_data2), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t mq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 0)
            foreach (mq[i])
                if (mq[i].a == a) begin
                    hit = 1'b1;
                    d   = mq[i].d;
                end
    endtask

    task automatic check_outputs();
        logic          full, empty, h1, h2;
        logic [DW-1:0] d1, d2;
        full  = (mq.size() == DEPTH);
        empty = (mq.size() == 0);
        model_lookup(q_addr1, h1, d1);
        model_lookup(q_addr2, h2, d2);
        chk("slow_ready", 32'(slow_ready), 32'(!full));
        chk("fast_ready", 32'(fast_ready), 32'(!full && !slow_valid));
        chk("rf_wen",     32'(rf_wen),     empty ? 32'h0 : 32'hF);
        chk("rf_waddr",   32'(rf_waddr),   empty ? 32'h0 : 32'(mq[0].a));
        chk("rf_wdata",   rf_wdata,        empty ? 32'h0 : mq[0].d);
        chk("q_count",    32'(q_count),    32'(mq.size()));
        chk("q_hit1",     32'(q_hit1),     32'(h1));
        chk("q_data1",    q_data1,         d1);
        chk("q_hit2",     32'(q_hit2),     32'(h2));
        chk("q_data2",    q_data2,         d2);
    endtask

    // One clock: drive at negedge, check before the rising edge, then advance the model.
    task automatic step(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                        input logic fv, input logic [AW-1:0] fa, input logic [DW-1:0] fd,
                        input logic rr, input logic [AW-1:0] qa1, input logic [AW-1:0] qa2);
        logic sacc, facc, pop;
        ent_t e;
        @(negedge clk);
        slow_valid = sv; slow_addr = sa; slow_data = sd;
        fast_valid = fv; fast_addr = fa; fast_data = fd;
        rf_ready = rr; q_addr1 = qa1; q_addr2 = qa2;
        #1;
        check_outputs();
        sacc = sv && (mq.size() < DEPTH);
        facc = fv && (mq.size() < DEPTH) && !sv;
        pop  = (mq.size() > 0) && rr;
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (sacc && sa != 0) begin
            e.a = sa; e.d = sd; mq.push_back(e);
        end else if (facc && fa != 0) begin
            e.a = fa; e.d = fd; mq.push_back(e);
        end
    endtask

    task automatic idle(input logic rr);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, rr, 5'd0, 5'd0);
    endtask

    initial begin
        #2;
        check_outputs();
        @(negedge clk);
        resetn = 1'b1;

        // single fast write, visible one cycle later, drained the next
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h12345678, 1'b1, 5'd5, 5'd0);
        idle(1'b1);
        idle(1'b1);
        chk("single_drained_count", 32'(q_count), 32'h0);

        // arbitration: slow wins, fast retried
        step(1'b1, 5'd3, 32'hAAAA0000, 1'b1, 5'd4, 32'hBBBB0000, 1'b1, 5'd3, 5'd4);
        step(1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'hBBBB0000, 1'b1, 5'd3, 5'd4);
        idle(1'b1);
        idle(1'b1);

        // fill under stall, then drain
        for (int i = 1; i <= 4; i++)
            step(1'b0, 5'd0, 32'h0, 1'b1, AW'(i), DW'(i), 1'b0, 5'd2, 5'd4);
        #1;
        chk("full_count", 32'(q_count), 32'd4);
        chk("full_fast_ready", 32'(fast_ready), 32'd0);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hA0, 1'b1, 5'd9, 5'd1);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // bypass returns youngest of two queued r7 writes
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd7, 5'd0);
        step(1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
        idle(1'b0);
        step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
        chk("bypass_young_data", q_data1, 32'h22);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0);

        // r0 write dropped
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 5'd0);
        idle(1'b1);
        chk("r0_drop_count", 32'(q_count), 32'h0);

        // asynchronous reset with three entries queued
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC1, 1'b0, 5'd12, 5'd13);
        step(1'b1, 5'd13, 32'hC2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd12, 5'd13);
        step(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'hC3, 1'b0, 5'd12, 5'd13);
        @(negedge clk);
        slow_valid = 1'b0; fast_valid = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_rf_wen",  32'(rf_wen),  32'h0);
        chk("rst_q_count", 32'(q_count), 32'h0);
        chk("rst_q_hit1",  32'(q_hit1),  32'h0);
        chk("rst_q_hit2",  32'(q_hit2),  32'h0);
        mq.delete();
        check_outputs();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) idle(1'b1);

        // random traffic: a stall-heavy phase then a drain-heavy phase
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
                 (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        for (int i = 0; i < DEPTH + 2; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
